// File: rtl/master_out_port.sv
// -----------------------------------------------------------------------------
// master_out_port
// Master-side serializer for the serial system bus. Takes one parallel request
// (read/write, address, first data beat, burst length) from master logic,
// handshakes with the slave port (master_valid / slave_ready) and shifts the
// address, data and burst frame out LSB-first on three 1-bit lines. For write
// bursts every further data beat is fetched through wdata_valid/wdata_ready
// and serialized in turn; read bursts hold read_en for one 12-cycle slot per
// extra beat.
//
// Build option: define MASTER_TIMEOUT_EN to abandon a request that the slave
// has not accepted within TIMEOUT cycles (tx_error pulses). Without it the
// block waits for slave_ready forever and tx_error is tied low.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   req_valid/req_ready request handshake (req_ready high only when idle)
//   req_write           1 = write, 0 = read
//   req_address         start address
//   req_data            first write data beat
//   req_burst_len       extra beats after the first (0 = single transfer)
//   wdata_valid/wdata   next burst write beat from master logic
//   wdata_ready         beat accepted this cycle
//   slave_ready         acceptance from slave port
//   master_valid        request on bus
//   read_en/write_en    transaction type, held for the whole transaction
//   tx_address/tx_data/tx_burst  serial lines
//   tx_done             one-cycle pulse in the last cycle of a transaction
//   tx_error            one-cycle timeout pulse (option only)
// -----------------------------------------------------------------------------
module master_out_port #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 12,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_address,
  input  logic [DATA_WIDTH-1:0]  req_data,
  input  logic [BURST_WIDTH-1:0] req_burst_len,
  input  logic                   wdata_valid,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic                   wdata_ready,
  input  logic                   slave_ready,
  output logic                   master_valid,
  output logic                   read_en,
  output logic                   write_en,
  output logic                   tx_address,
  output logic                   tx_data,
  output logic                   tx_burst,
  output logic                   tx_done,
  output logic                   tx_error
);

  localparam int CNT_W = $clog2((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("master_out_port: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, WAIT_HS, SEND, GAP, BEAT, RBURST} state_t;

  state_t                 state_reg, state_next;
  logic                   write_reg;
  logic [BURST_WIDTH-1:0] len_reg;
  logic [ADDR_WIDTH-1:0]  addr_sr;
  logic [DATA_WIDTH-1:0]  data_sr;
  logic [BURST_WIDTH:0]   burst_sr;       // {len, flag}; shifts once per cycle after the handshake
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [BURST_WIDTH:0]   beat_cnt_reg;   // one bit wider than len so len = max never wraps
  logic [BURST_WIDTH:0]   beat_inc;
  logic                   len_zero;

  assign len_zero = (len_reg == '0);
  assign beat_inc = beat_cnt_reg + {{BURST_WIDTH{1'b0}}, 1'b1};

`ifdef MASTER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              timeout_hit;
  logic              tx_error_reg;
`endif

  // Next state and handshake outputs
  always_comb begin
    state_next   = state_reg;
    req_ready    = 1'b0;
    master_valid = 1'b0;
    wdata_ready  = 1'b0;
    tx_done      = 1'b0;
`ifdef MASTER_TIMEOUT_EN
    timeout_hit  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = WAIT_HS;
      end
      WAIT_HS: begin
        master_valid = 1'b1;
        if (slave_ready) begin
          state_next = SEND;
        end
`ifdef MASTER_TIMEOUT_EN
        else if (wait_cnt_reg == WAIT_LAST) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      SEND: begin
        if (bit_cnt_reg == ADDR_LAST) begin
          if (len_zero) begin
            tx_done    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = write_reg ? GAP : RBURST;
          end
        end
      end
      GAP: begin
        wdata_ready = wdata_valid;
        if (wdata_valid) state_next = BEAT;
      end
      BEAT: begin
        if (bit_cnt_reg == DATA_LAST) begin
          if (beat_inc > {1'b0, len_reg}) begin
            tx_done    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = GAP;
          end
        end
      end
      RBURST: begin
        if (bit_cnt_reg == ADDR_LAST && beat_cnt_reg >= {1'b0, len_reg}) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, shift registers and counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      write_reg    <= 1'b0;
      len_reg      <= '0;
      addr_sr      <= '0;
      data_sr      <= '0;
      burst_sr     <= '0;
      bit_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          bit_cnt_reg  <= '0;
          beat_cnt_reg <= '0;
          if (req_valid) begin
            write_reg <= req_write;
            len_reg   <= req_burst_len;
            addr_sr   <= req_address;
            // reads keep tx_data low simply by serializing zeros
            data_sr   <= req_write ? req_data : '0;
            burst_sr  <= (req_burst_len == '0) ? '0 : {req_burst_len, 1'b1};
          end
        end
        WAIT_HS: begin
          if (slave_ready) begin
            addr_sr     <= addr_sr >> 1;
            data_sr     <= data_sr >> 1;
            burst_sr    <= burst_sr >> 1;
            bit_cnt_reg <= CNT_W'(1);
          end
        end
        SEND: begin
          addr_sr  <= addr_sr >> 1;
          data_sr  <= data_sr >> 1;
          burst_sr <= burst_sr >> 1;
          if (bit_cnt_reg == ADDR_LAST) begin
            bit_cnt_reg  <= '0;
            beat_cnt_reg <= {{BURST_WIDTH{1'b0}}, 1'b1};
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          // the 13-bit frame outlasts the 12-cycle SEND, so keep shifting here
          burst_sr <= burst_sr >> 1;
          if (wdata_valid) data_sr <= wdata;
        end
        BEAT: begin
          burst_sr <= burst_sr >> 1;
          data_sr  <= data_sr >> 1;
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_reg  <= '0;
            beat_cnt_reg <= beat_inc;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        RBURST: begin
          burst_sr <= burst_sr >> 1;
          if (bit_cnt_reg == ADDR_LAST) begin
            bit_cnt_reg  <= '0;
            beat_cnt_reg <= beat_inc;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MASTER_TIMEOUT_EN
  // Counts cycles spent in WAIT_HS; tx_error is registered so it appears in
  // the first idle cycle, together with master_valid/read_en/write_en dropping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_reg <= '0;
      tx_error_reg <= 1'b0;
    end else begin
      tx_error_reg <= timeout_hit;
      if (state_reg == WAIT_HS && !slave_ready) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                                      wait_cnt_reg <= '0;
    end
  end
  assign tx_error = tx_error_reg;
`else
  assign tx_error = 1'b0;
`endif

  assign read_en    = (state_reg != IDLE) && !write_reg;
  assign write_en   = (state_reg != IDLE) &&  write_reg;
  assign tx_address = ((state_reg == WAIT_HS) || (state_reg == SEND)) && addr_sr[0];
  assign tx_data    = ((state_reg == WAIT_HS) || (state_reg == SEND) || (state_reg == BEAT)) && data_sr[0];
  assign tx_burst   = (state_reg != IDLE) && burst_sr[0];

endmodule

// File: tb/tb_master_out_port.sv
// -----------------------------------------------------------------------------
// tb_master_out_port
// Transaction-level bench: each request is expanded into a cycle-by-cycle list
// of stimulus and expected bus activity derived from the bus rules (handshake
// wait, 12-bit address frame, 8-bit data frames, 13-bit burst frame, gaps and
// read slots), then driven and compared every cycle.
// -----------------------------------------------------------------------------
module tb_master_out_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_address;
  logic [7:0]  req_data;
  logic [11:0] req_burst_len;
  logic        wdata_valid;
  logic [7:0]  wdata;
  logic        wdata_ready;
  logic        slave_ready;
  logic        master_valid;
  logic        read_en;
  logic        write_en;
  logic        tx_address;
  logic        tx_data;
  logic        tx_burst;
  logic        tx_done;
  logic        tx_error;

  always #5 clk = ~clk;

  master_out_port dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data), .req_burst_len(req_burst_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .slave_ready(slave_ready), .master_valid(master_valid),
    .read_en(read_en), .write_en(write_en),
    .tx_address(tx_address), .tx_data(tx_data), .tx_burst(tx_burst),
    .tx_done(tx_done), .tx_error(tx_error)
  );

  // One cycle of the expanded transaction: inputs to drive and outputs expected.
  typedef struct {
    logic       sr;
    logic       wv;
    logic       rv;
    logic [7:0] wd;
    logic [9:0] exp;
  } step_t;

  localparam int DONE_BIT = 2;

  int checks   = 0;
  int failures = 0;
  int txn_no   = 0;

  // Expected vector order: req_ready, master_valid, read_en, write_en,
  // tx_address, tx_data, tx_burst, tx_done, wdata_ready, tx_error
  function automatic logic [9:0] pack(input logic rr, input logic mv, input logic re,
                                      input logic we, input logic ta, input logic td,
                                      input logic tb, input logic dn, input logic wr,
                                      input logic er);
    return {rr, mv, re, we, ta, td, tb, dn, wr, er};
  endfunction

  // Burst frame bit at position p counted from the handshake cycle.
  function automatic logic frame_bit(input logic [11:0] len, input int p);
    if (len == 12'd0) return 1'b0;
    if (p == 0)       return 1'b1;
    if (p <= 12)      return len[p-1];
    return 1'b0;
  endfunction

  task automatic check(input string tag, input int idx, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {req_ready, master_valid, read_en, write_en, tx_address, tx_data,
           tx_burst, tx_done, wdata_ready, tx_error};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%b expected=%b (rr mv re we ta td tb dn wr er)",
             tag, idx, obs, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [11:0] addr,
                         input logic [7:0] d0, input logic [11:0] len, input int hs_delay,
                         input int gap_min, input int gap_max, input logic [7:0] b1,
                         input logic [7:0] b2, input int abort_at);
    step_t      q[$];
    step_t      s;
    int         pos;
    int         g;
    int         nslot;
    logic [7:0] beat;
    logic       re;
    logic       we;
    bit         aborted;
    re      = ~wr;
    we      = wr;
    aborted = 1'b0;

    // Request cycle in IDLE
    @(negedge clk);
    req_valid     = 1'b1;
    req_write     = wr;
    req_address   = addr;
    req_data      = d0;
    req_burst_len = len;
    slave_ready   = 1'($urandom);
    wdata_valid   = 1'($urandom);
    wdata         = 8'($urandom);
    #1 check({tag, "_req"}, 0, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Waiting for the slave: bit 0 of each frame on the lines
    for (int i = 0; i < hs_delay; i++) begin
      s.sr = 1'b0; s.wv = 1'($urandom); s.rv = 1'($urandom); s.wd = 8'($urandom);
      s.exp = pack(0, 1, re, we, addr[0], wr & d0[0], frame_bit(len, 0), 0, 0, 0);
      q.push_back(s);
    end
    // Handshake cycle plus 11 further address bits
    pos = 0;
    for (int k = 0; k < 12; k++) begin
      s.sr = (k == 0) ? 1'b1 : 1'($urandom);
      s.wv = 1'($urandom); s.rv = 1'($urandom); s.wd = 8'($urandom);
      s.exp = pack(0, (k == 0), re, we, addr[k], (wr && k < 8) ? d0[k % 8] : 1'b0,
                   frame_bit(len, pos), 0, 0, 0);
      pos++;
      q.push_back(s);
    end
    if (wr && len != 12'd0) begin
      for (int b = 1; b <= int'(len); b++) begin
        g    = int'($urandom_range(gap_max, gap_min));
        beat = (b == 1) ? b1 : (b == 2) ? b2 : 8'($urandom);
        for (int j = 0; j < g; j++) begin
          s.sr = 1'($urandom); s.wv = 1'b0; s.rv = 1'($urandom); s.wd = 8'($urandom);
          s.exp = pack(0, 0, 0, 1, 0, 0, frame_bit(len, pos), 0, 0, 0);
          pos++;
          q.push_back(s);
        end
        s.sr = 1'($urandom); s.wv = 1'b1; s.rv = 1'($urandom); s.wd = beat;
        s.exp = pack(0, 0, 0, 1, 0, 0, frame_bit(len, pos), 0, 1, 0);
        pos++;
        q.push_back(s);
        for (int k = 0; k < 8; k++) begin
          s.sr = 1'($urandom); s.wv = 1'($urandom); s.rv = 1'($urandom); s.wd = 8'($urandom);
          s.exp = pack(0, 0, 0, 1, 0, beat[k], frame_bit(len, pos), 0, 0, 0);
          pos++;
          q.push_back(s);
        end
      end
    end else if (!wr && len != 12'd0) begin
      nslot = 12 * int'(len);
      for (int c = 0; c < nslot; c++) begin
        s.sr = 1'($urandom); s.wv = 1'($urandom); s.rv = 1'($urandom); s.wd = 8'($urandom);
        s.exp = pack(0, 0, 1, 0, 0, 0, frame_bit(len, pos), 0, 0, 0);
        pos++;
        q.push_back(s);
      end
    end
    q[q.size()-1].exp[DONE_BIT] = 1'b1;

    // Drive and compare; request inputs carry noise that must be ignored
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 check({tag, "_after_reset"}, i, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        aborted = 1'b1;
        break;
      end
      slave_ready   = q[i].sr;
      wdata_valid   = q[i].wv;
      wdata         = q[i].wd;
      req_valid     = q[i].rv;
      req_write     = 1'($urandom);
      req_address   = 12'($urandom);
      req_data      = 8'($urandom);
      req_burst_len = 12'($urandom);
      #1 check(tag, i + 1, q[i].exp);
    end

    // Back in IDLE the cycle after the transaction ends
    @(negedge clk);
    req_valid   = 1'b0;
    slave_ready = 1'($urandom);
    wdata_valid = 1'($urandom);
    #1 check({tag, "_idle"}, q.size() + 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    txn_no++;
    $display("TXN %0d %s wr=%0b addr=%03h data=%02h len=%0d hs_wait=%0d steps=%0d aborted=%0b",
             txn_no, tag, wr, addr, d0, len, hs_delay, q.size(), aborted);
  endtask

  initial begin
    reset         = 1'b0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_address   = '0;
    req_data      = '0;
    req_burst_len = '0;
    wdata_valid   = 1'b0;
    wdata         = '0;
    slave_ready   = 1'b0;

    repeat (2) @(negedge clk);
    #1 check("reset_state", 0, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;

    run_txn("single_wr",  1'b1, 12'hA5C, 8'h3B, 12'd0, 0,  0, 0, 8'h00, 8'h00, -1);
    run_txn("hs_stall",   1'b1, 12'h3C7, 8'hD2, 12'd0, 20, 0, 0, 8'h00, 8'h00, -1);
    run_txn("wr_burst2",  1'b1, 12'h123, 8'hE7, 12'd2, 0,  3, 3, 8'h11, 8'h22, -1);
    run_txn("rd_burst3",  1'b0, 12'h8F1, 8'hFF, 12'd3, 0,  0, 0, 8'h00, 8'h00, -1);
    run_txn("rd_single",  1'b0, 12'hFFF, 8'hAA, 12'd0, 2,  0, 0, 8'h00, 8'h00, -1);
    run_txn("wr_burst1",  1'b1, 12'h001, 8'h80, 12'd1, 1,  0, 0, 8'hC3, 8'h00, -1);
    run_txn("reset_send", 1'b1, 12'h5A5, 8'h7E, 12'd4, 2,  0, 0, 8'h00, 8'h00, 7);
    run_txn("after_rst",  1'b1, 12'hABC, 8'h96, 12'd0, 0,  0, 0, 8'h00, 8'h00, -1);
    run_txn("rd_long",    1'b0, 12'h7E1, 8'h00, 12'h801, 1, 0, 0, 8'h00, 8'h00, -1);

    for (int t = 0; t < 16; t++) begin
      logic [11:0] rlen;
      rlen = ($urandom_range(3, 0) == 0) ? 12'd0 : 12'($urandom_range(6, 1));
      run_txn("random", 1'($urandom), 12'($urandom), 8'($urandom), rlen,
              int'($urandom_range(4, 0)), 0, 3, 8'($urandom), 8'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
